// File: rtl/if_stage_if.sv
// Fetch-stage bundle: instruction-memory handshake, ID-side delivery and redirect.
// The master modport is the fetch stage; the slave modport is its environment.
interface if_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              id_stall;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic [DATA_W-1:0] im_instruction;
    logic [ADDR_W-1:0] if_pc;
    logic [ADDR_W-1:0] if_pc_next;
    logic              if_valid;
    logic [1:0]        buf_count;

    modport master (
        output mem_req, mem_addr, im_instruction, if_pc, if_pc_next, if_valid, buf_count,
        input  mem_ack, mem_rdata, id_stall, br_taken, br_target
    );

    modport slave (
        input  mem_req, mem_addr, im_instruction, if_pc, if_pc_next, if_valid, buf_count,
        output mem_ack, mem_rdata, id_stall, br_taken, br_target
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC generation, req/ack fetch with one outstanding request,
// 2-entry prefetch FIFO to ID, and redirect handling with squash of in-flight fetches.
module if_stage #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] PC_INC   = ADDR_W'(1)
) (
    input  logic       CLK,
    input  logic       RST,
    if_stage_if.master bus
);
    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc, r_flush_addr;
    logic [ADDR_W-1:0] r_pc0, r_pc1;
    logic [DATA_W-1:0] r_data0, r_data1;
    logic [1:0]        r_count;
    logic              w_mem_req;
    logic [ADDR_W-1:0] w_mem_addr;
    logic              w_valid, w_push, w_pop;

    // Entry 0 is always the FIFO head, so outputs come straight from registers.
    assign w_valid = (r_count != 2'd0);
    assign w_push  = (r_state == RUN) && w_mem_req && bus.mem_ack && !bus.br_taken;
    assign w_pop   = w_valid && !bus.id_stall && !bus.br_taken;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= RUN;
        else     r_state <= w_state_nxt;
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_mem_req   = 1'b0;
        w_mem_addr  = r_fetch_pc;
        case (r_state)
            RUN: begin
                w_mem_req  = !RST && (r_count < 2'd2);
                w_mem_addr = r_fetch_pc;
            end
            FLUSH: begin
                w_mem_req  = !RST;
                w_mem_addr = r_flush_addr;
                if (w_mem_req && bus.mem_ack) w_state_nxt = RUN;
            end
            default: w_state_nxt = RUN;
        endcase
        // A redirect only has to wait out a request that is still unacknowledged.
        if (bus.br_taken) w_state_nxt = (w_mem_req && !bus.mem_ack) ? FLUSH : RUN;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            // NOTE: the FIFO entries are reset too; the head drives im_instruction/if_pc directly.
            r_fetch_pc   <= RESET_PC;
            r_flush_addr <= RESET_PC;
            r_count      <= '0;
            r_pc0        <= '0;
            r_pc1        <= '0;
            r_data0      <= '0;
            r_data1      <= '0;
        end else if (bus.br_taken) begin
            r_fetch_pc <= bus.br_target;
            r_count    <= '0;
            if (r_state == RUN && w_state_nxt == FLUSH) r_flush_addr <= r_fetch_pc;
        end else begin
            if (w_push) r_fetch_pc <= r_fetch_pc + PC_INC;
            r_count <= r_count + 2'(w_push) - 2'(w_pop);

            if (w_pop && r_count == 2'd2) begin
                r_pc0   <= r_pc1;
                r_data0 <= r_data1;
            end else if (w_push && (r_count == 2'd0 || w_pop)) begin
                r_pc0   <= r_fetch_pc;
                r_data0 <= bus.mem_rdata;
            end

            if (w_push && r_count == 2'd1 && !w_pop) begin
                r_pc1   <= r_fetch_pc;
                r_data1 <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_req        = w_mem_req;
    assign bus.mem_addr       = w_mem_addr;
    assign bus.im_instruction = r_data0;
    assign bus.if_pc          = r_pc0;
    assign bus.if_pc_next     = r_pc0 + PC_INC;
    assign bus.if_valid       = w_valid;
    assign bus.buf_count      = r_count;
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: streaming, stall, FLUSH squash, redirect drop, PC wrap
// and asynchronous reset mid-FLUSH, with hand-computed expected values.
module tb_if_stage;
    localparam int DW = 32;
    localparam int AW = 32;

    logic CLK = 1'b0;
    logic RST;

    if_stage_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    if_stage #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .RESET_PC(32'h0),
        .PC_INC  (32'h1)
    ) u_dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Zero-wait memory: ack whatever is requested, returning 0x1000_0000 + address.
    task automatic zw_respond();
        #1;
        bus.mem_ack   = bus.mem_req;
        bus.mem_rdata = 32'h1000_0000 + bus.mem_addr;
    endtask

    task automatic head_is(input string tag, input logic [31:0] pc, input logic [31:0] ins);
        chk({tag, "_valid"}, 32'(bus.if_valid), 32'd1);
        chk({tag, "_pc"}, bus.if_pc, pc);
        chk({tag, "_pcn"}, bus.if_pc_next, pc + 32'd1);
        chk({tag, "_ins"}, bus.im_instruction, ins);
    endtask

    initial begin
        RST           = 1'b1;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        bus.id_stall  = 1'b0;
        bus.br_taken  = 1'b0;
        bus.br_target = '0;
        tick();
        tick();

        // Reset state
        chk("rst_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_ins", bus.im_instruction, 32'h0);
        chk("rst_pc", bus.if_pc, 32'h0);
        chk("rst_pcn", bus.if_pc_next, 32'h1);
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_cnt", 32'(bus.buf_count), 32'd0);

        // Release: first request is RESET_PC in the release cycle
        RST = 1'b0;
        #1;
        chk("c0_req", 32'(bus.mem_req), 32'd1);
        chk("c0_addr", bus.mem_addr, 32'h0);
        zw_respond();
        tick();

        // First valid one cycle after the ack; stall ID for 5 cycles here
        head_is("c1", 32'h0, 32'h1000_0000);
        chk("c1_addr", bus.mem_addr, 32'h1);
        chk("c1_cnt", 32'(bus.buf_count), 32'd1);
        bus.id_stall = 1'b1;
        zw_respond();
        tick();
        for (int i = 0; i < 4; i++) begin
            head_is("stall", 32'h0, 32'h1000_0000);
            chk("stall_cnt", 32'(bus.buf_count), 32'd2);
            chk("stall_req", 32'(bus.mem_req), 32'd0);
            zw_respond();
            tick();
        end

        // Release stall: head still held this cycle, pop at the edge
        head_is("unstall", 32'h0, 32'h1000_0000);
        chk("unstall_req", 32'(bus.mem_req), 32'd0);
        bus.id_stall = 1'b0;
        zw_respond();
        tick();

        head_is("c7", 32'h1, 32'h1000_0001);
        chk("c7_req", 32'(bus.mem_req), 32'd1);
        chk("c7_addr", bus.mem_addr, 32'h2);
        chk("c7_cnt", 32'(bus.buf_count), 32'd1);
        zw_respond();
        tick();

        // Redirect to 0x80 with ack of 0x3 and a pop in the same cycle
        head_is("c8", 32'h2, 32'h1000_0002);
        chk("c8_addr", bus.mem_addr, 32'h3);
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h80;
        zw_respond();
        tick();
        bus.br_taken = 1'b0;
        chk("br80_valid", 32'(bus.if_valid), 32'd0);
        chk("br80_cnt", 32'(bus.buf_count), 32'd0);
        chk("br80_req", 32'(bus.mem_req), 32'd1);
        chk("br80_addr", bus.mem_addr, 32'h80);
        zw_respond();
        tick();
        head_is("c10", 32'h80, 32'h1000_0080);

        // Redirect to 0x2 (acked, no flush), then latency memory
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h2;
        zw_respond();
        tick();
        bus.br_taken = 1'b0;
        bus.mem_ack  = 1'b0;
        chk("c11_valid", 32'(bus.if_valid), 32'd0);
        chk("c11_addr", bus.mem_addr, 32'h2);
        tick();

        // Redirect to 0x40 while 0x2 is unacked -> FLUSH
        chk("c12_req", 32'(bus.mem_req), 32'd1);
        chk("c12_addr", bus.mem_addr, 32'h2);
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h40;
        tick();
        bus.br_taken = 1'b0;
        chk("flush_req", 32'(bus.mem_req), 32'd1);
        chk("flush_addr", bus.mem_addr, 32'h2);
        chk("flush_valid", 32'(bus.if_valid), 32'd0);
        chk("flush_cnt", 32'(bus.buf_count), 32'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEAD_0002;
        tick();
        bus.mem_ack = 1'b0;
        chk("post_flush_valid", 32'(bus.if_valid), 32'd0);
        chk("post_flush_cnt", 32'(bus.buf_count), 32'd0);
        chk("post_flush_addr", bus.mem_addr, 32'h40);
        tick();
        chk("c15_addr", bus.mem_addr, 32'h40);
        chk("c15_valid", 32'(bus.if_valid), 32'd0);
        tick();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1000_0040;
        tick();
        bus.mem_ack = 1'b0;
        head_is("c17", 32'h40, 32'h1000_0040);

        // Wrap: redirect to 0xFFFF_FFFF
        bus.br_taken  = 1'b1;
        bus.br_target = 32'hFFFF_FFFF;
        zw_respond();
        tick();
        bus.br_taken = 1'b0;
        chk("wrap_addr", bus.mem_addr, 32'hFFFF_FFFF);
        zw_respond();
        tick();
        chk("wrap_pc", bus.if_pc, 32'hFFFF_FFFF);
        chk("wrap_pcn", bus.if_pc_next, 32'h0);
        chk("wrap_ins", bus.im_instruction, 32'h0FFF_FFFF);
        chk("wrap_next_addr", bus.mem_addr, 32'h0);
        zw_respond();
        tick();
        head_is("c20", 32'h0, 32'h1000_0000);
        chk("c20_addr", bus.mem_addr, 32'h1);

        // Enter FLUSH on 0x1, then reset mid-FLUSH with a stray ack
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h100;
        bus.mem_ack   = 1'b0;
        tick();
        bus.br_taken = 1'b0;
        chk("c21_req", 32'(bus.mem_req), 32'd1);
        chk("c21_addr", bus.mem_addr, 32'h1);
        RST         = 1'b1;
        bus.mem_ack = 1'b1;
        #1;
        chk("arst_req", 32'(bus.mem_req), 32'd0);
        chk("arst_valid", 32'(bus.if_valid), 32'd0);
        chk("arst_cnt", 32'(bus.buf_count), 32'd0);
        chk("arst_ins", bus.im_instruction, 32'h0);
        chk("arst_pc", bus.if_pc, 32'h0);
        chk("arst_pcn", bus.if_pc_next, 32'h1);
        tick();
        RST         = 1'b0;
        bus.mem_ack = 1'b0;
        #1;
        chk("rel_cnt", 32'(bus.buf_count), 32'd0);
        chk("rel_req", 32'(bus.mem_req), 32'd1);
        chk("rel_addr", bus.mem_addr, 32'h0);
        tick();
        chk("c23_valid", 32'(bus.if_valid), 32'd0);
        zw_respond();
        tick();
        head_is("c24", 32'h0, 32'h1000_0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage sitting directly upstream of the decode stage (ID).
- Generates the program counter, fetches instruction words from instruction memory over a req/ack handshake, and buffers them in a 2-entry prefetch FIFO.
- Presents `im_instruction` plus its PC to ID.
- Handles back-pressure from ID (stall) and PC redirects from branch/jump resolution, including squashing of in-flight fetches.

Parameters:
- DATA_W, 32, instruction width.
- ADDR_W, 32, PC/address width.
- RESET_PC, 32'h0, first fetch address after reset.
- PC_INC, 1, PC increment per instruction (word-addressed memory).

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  asynchronous active-high reset.
- mem_req  out  1  fetch request to instruction memory.
- mem_addr  out  ADDR_W  fetch address; stable while mem_req high and not acked.
- mem_ack  in  1  transfer completes in a cycle with mem_req && mem_ack.
- mem_rdata  in  DATA_W  instruction word, valid in the ack cycle.
- id_stall  in  1  ID not accepting; hold current output.
- br_taken  in  1  redirect PC this cycle.
- br_target  in  ADDR_W  redirect address.
- im_instruction  out  DATA_W  instruction to ID (FIFO head).
- if_pc  out  ADDR_W  PC of im_instruction.
- if_pc_next  out  ADDR_W  if_pc + PC_INC (link value, feeds rb_WPC).
- if_valid  out  1  im_instruction/if_pc valid.
- buf_count  out  2  FIFO occupancy 0..2 (debug/verification).

Behaviour:
- Reset (async, RST=1):
  - fetch_pc=RESET_PC, FIFO empty, state=RUN.
  - if_valid=0, im_instruction=0, if_pc=0, if_pc_next=PC_INC.
  - mem_req=0, buf_count=0.
- Outputs:
  - mem_req = !RST && (state==FLUSH || (state==RUN && buf_count<2)).
  - mem_addr = fetch_pc in RUN; the squashed address in FLUSH.
  - im_instruction/if_pc are driven from FIFO head registers (no combinational path from mem_rdata).
  - if_valid = (buf_count!=0) && state!=FLUSH-squash; only real entries are ever visible.
- One outstanding request maximum. Zero-wait memory (ack in the same cycle as req) is legal.
- Latency: ack at edge N -> if_valid=1 with that word after edge N. First fetch is RESET_PC, issued the cycle RST deasserts.
- Enqueue: in RUN, on mem_req && mem_ack, push {fetch_pc, mem_rdata}; fetch_pc += PC_INC (wraps modulo 2^ADDR_W).
- Dequeue: on if_valid && !id_stall, pop head.
  - Enqueue and dequeue in the same cycle: count unchanged, order preserved.
  - Full (count=2) with no dequeue: mem_req=0; resumes the cycle after a pop.
- Stall: while id_stall=1, im_instruction/if_pc/if_valid are held bit-stable. Fetching continues until full.
- FSM states:
  - RUN: normal operation.
  - FLUSH: a squashed request is still pending; keep mem_req=1 with the old address until ack, discard that data, then go to RUN.
- Redirect (br_taken=1 at edge), highest priority:
  - FIFO cleared (count=0), fetch_pc <= br_target.
  - Any same-cycle dequeue or enqueue is dropped.
  - If mem_req && !mem_ack (unacked request in flight): state -> FLUSH. Otherwise state stays RUN and the next cycle requests br_target.
  - br_taken while in FLUSH: fetch_pc updated to the new target, stay in FLUSH.
  - if_valid=0 the cycle after any redirect.
- Reset mid-transfer: all state cleared immediately; a late mem_ack after reset release with mem_req=0 is ignored.

Test Plan:
- Reset, zero-wait memory returning mem[a]=32'h1000_0000+a, id_stall=0 -> mem_addr 0,1,2,…; if_valid rises one cycle after the first ack; im_instruction 32'h1000_0000, 32'h1000_0001, … with if_pc 0,1,2 and if_pc_next 1,2,3.
- id_stall=1 for 5 cycles after the first valid -> im_instruction/if_pc held at 32'h1000_0000/0; buf_count reaches 2; mem_req=0 while full; after release the sequence resumes with no skipped or duplicated PC.
- 3-cycle-latency memory, br_taken with br_target=32'h40 while a request to 0x2 is unacked -> FLUSH; mem_addr stays 0x2 until ack; that data is never visible; next request is 0x40; first valid if_pc=0x40.
- Zero-wait memory, br_taken with br_target=0x80 on the same cycle as ack of 0x3 and an ID pop -> 0x3 discarded; FIFO empty; if_valid=0 next cycle; next fetch is 0x80.
- fetch_pc=32'hFFFF_FFFF -> next fetch address 0x0 (wrap); if_pc_next=0 for the 0xFFFF_FFFF instruction.
- RST asserted for 1 cycle mid-FLUSH with a request pending -> outputs immediately at reset values; after release the first request is RESET_PC; a stray ack in the release cycle is ignored (buf_count stays 0).
